aes_subbytes_simd: RTL and testbench
====================================

# aes_subbytes_simd

Sequential SubBytes stage of the AES datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes all 16 bytes through LANES parallel S-box lanes, one group of LANES bytes per cycle. It returns the substituted state over a second valid/ready handshake. It sits between AddRoundKey (upstream) and ShiftRows (downstream); each lane drives one `aes_sbox` instance.

## Interface
Parameters:
- LANES, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16 (must divide 16). STEPS = 16/LANES.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream presents in_state
- in_ready  out  1  block can accept a state
- in_state  in  128  input state; byte i = in_state[127-8i -: 8] (FIPS-197 byte order, byte 0 in MSBs)
- out_valid  out  1  out_state holds a fully substituted state
- out_ready  in  1  downstream accepts out_state
- out_state  out  128  substituted state, same byte order
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; out_valid=0.
  - On in_valid&&in_ready, latch in_state into the 128-bit buffer, clear step counter to 0, go to RUN.
- RUN:
  - Each cycle, lane l (0..LANES-1) substitutes byte k = step*LANES+l of the buffer in place.
  - S-box lookup: row = byte[7:4], col = byte[3:0].
  - Step counter increments each cycle. On step==STEPS-1, write the last group and go to DONE.
- DONE:
  - out_valid=1; out_state=buffer.
  - On out_ready, go to IDLE.
- in_ready is high only in IDLE. There is no accept in DONE, and no overlap between consecutive blocks.
- Step counter width is $clog2(STEPS), with a minimum of 1 bit. It never wraps past STEPS-1; leaving RUN resets it to 0.
- Bytes not yet reached in RUN keep their input value. Bytes already written keep their substituted value.

## Timing
- Reset values: FSM=IDLE, counter=0, buffer=0, out_valid=0, out_state=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst deasserts.
- Reset is asynchronous and takes effect immediately in any state. A block in RUN or DONE is discarded with no output.
- Latency from the accept edge to out_valid high is STEPS cycles (4 for LANES=4; 16 for LANES=1).
- Minimum initiation interval is STEPS+2 cycles (accept, STEPS RUN cycles, DONE handshake, return to IDLE).
- Input data is sampled only on the accept edge. in_state may change freely at any other time.
- While out_valid is high and out_ready is low:
  - out_state and out_valid hold stable.
  - in_ready stays 0.
- out_ready already high when DONE is entered: handshake completes in the first DONE cycle; IDLE on the next edge.
- in_valid is ignored outside IDLE.
- in_valid high in the same cycle that DONE hands off does not get accepted until IDLE.

## Structure
- Shared package `aes_pkg` holds:
  - AES_STATE_W=128 and AES_BYTES=16.
  - typedef logic [127:0] aes_state_t.
  - typedef logic [7:0] aes_byte_t.
  - FSM enum `subbytes_state_e` {IDLE, RUN, DONE}.
- Sub-module: LANES instances of `aes_sbox` (4-bit row, 4-bit col in; 8-bit out), created in a generate loop.
- Byte select and write-back are indexed muxes on the buffer. Substitution is purely combinational within a step.

## Test plan
- FIPS vector, LANES=4:
  - Stimulus: in_state=128'h00112233445566778899AABBCCDDEEFF, out_ready=1.
  - Required: out_state=128'h638293C31BFC33F5C4EEACEA4BC12816; out_valid exactly 4 cycles after accept.
- Constants:
  - All-zero state -> 16×8'h63.
  - All-FF state -> 16×8'h16.
  - Back-to-back blocks: accepts spaced exactly 6 cycles apart.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_state stays stable; in_ready=0; busy=1.
  - Raising out_ready yields one handshake, then IDLE.
- Reset mid-RUN: assert rst at step 2.
  - Same cycle: out_valid=0, busy=0, out_state=0.
  - After release: in_ready=1; the next block (all-FF) returns 16×8'h16.
- Parameter sweep LANES=1, 2, 16 with the FIPS vector:
  - Identical output.
  - Latency 16, 8 and 1 cycles respectively.
- Random: 1000 random states with random in_valid/out_ready gaps, checked against a software S-box model. No lost or duplicated blocks.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and the FIPS-197 S-box table for the SubBytes stage.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } subbytes_state_e;

  // Entry 0x00 sits in the MSBs; entry n is at [2047-8n -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic aes_byte_t sbox_lookup(input logic [3:0] row, input logic [3:0] col);
    logic [7:0] idx;
    idx = {row, col};
    return SBOX_TABLE[2047 - 8 * int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// One combinational AES S-box lane addressed by row (high nibble) and column (low nibble).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output aes_byte_t  sub_o
);

  assign sub_o = sbox_lookup(row_i, col_i);

endmodule

// File: rtl/aes_subbytes_simd.sv
// Sequential SubBytes: latches a 128-bit state, substitutes LANES bytes per cycle in place,
// then presents the result over a valid/ready handshake.
module aes_subbytes_simd
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  aes_state_t in_state,
  output logic       out_valid,
  input  logic       out_ready,
  output aes_state_t out_state,
  output logic       busy
);

  localparam int STEPS = AES_BYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  subbytes_state_e  state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  aes_state_t       buf_q, buf_d;
  logic             in_ready_q, out_valid_q, busy_q;

  aes_byte_t lane_in  [LANES];
  aes_byte_t lane_out [LANES];

  // Select the group of bytes addressed by the current step.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = buf_q[AES_STATE_W - 1 - 8 * (int'(step_q) * LANES + l) -: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .row_i (lane_in[g][7:4]),
      .col_i (lane_in[g][3:0]),
      .sub_o (lane_out[g])
    );
  end

  // Next-state, step counter and in-place write-back of the substituted group.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          buf_d   = in_state;
          step_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          buf_d[AES_STATE_W - 1 - 8 * (int'(step_q) * LANES + l) -: 8] = lane_out[l];
        end
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = DONE;
        end else begin
          step_d  = step_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        step_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      buf_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      buf_q       <= buf_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = buf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_subbytes_simd.sv
// Directed and randomised checks of aes_subbytes_simd against an S-box derived from GF(2^8) arithmetic.
module tb_aes_subbytes_simd;

  localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] FIPS_OUT = 128'h638293C31BFC33F5C4EEACEA4BC12816;
  localparam logic [127:0] ALL_63   = 128'h63636363636363636363636363636363;
  localparam logic [127:0] ALL_16   = 128'h16161616161616161616161616161616;
  localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] SEQ_OUT  = 128'h637C777BF26B6FC53001672BFED7AB76;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
  logic         busy;

  logic         sw_valid = 1'b0;
  logic [127:0] sw_state = '0;
  logic [2:0]   sw_rdy, sw_ov, sw_busy;
  logic [127:0] sw_out [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int acc_cyc [$];
  logic [127:0] exp_q [$];
  logic [7:0] sbox_tab [256];

  always #5 clk = ~clk;

  aes_subbytes_simd #(.LANES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy));

  aes_subbytes_simd #(.LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[0]), .in_state(sw_state),
    .out_valid(sw_ov[0]), .out_ready(1'b1), .out_state(sw_out[0]), .busy(sw_busy[0]));

  aes_subbytes_simd #(.LANES(2)) u_l2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[1]), .in_state(sw_state),
    .out_valid(sw_ov[1]), .out_ready(1'b1), .out_state(sw_out[1]), .busy(sw_busy[1]));

  aes_subbytes_simd #(.LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_rdy[2]), .in_state(sw_state),
    .out_valid(sw_ov[2]), .out_ready(1'b1), .out_state(sw_out[2]), .busy(sw_busy[2]));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      b = s[127 - 8 * i -: 8];
      r[127 - 8 * i -: 8] = sbox_tab[b];
    end
    return r;
  endfunction

  // Scoreboard: expected results queued at accept, compared at output handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(sub_state(in_state));
        acc_cyc.push_back(cyc);
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) check_val("sb_extra_output", 128'd1, 128'd0);
        else check_val("sb_out", out_state, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_wait(input logic [127:0] s, output int lat, output logic [127:0] res);
    int w;
    w = 0;
    lat = 0;
    res = '0;
    while (!in_ready && w < 40) begin tick(); w++; end
    if (!in_ready) begin check_val("in_ready_timeout", 128'd0, 128'd1); return; end
    in_valid = 1'b1;
    in_state = s;
    tick();
    in_valid = 1'b0;
    in_state = ~s;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    if (!out_valid) check_val("out_valid_timeout", 128'd0, 128'd1);
    res = out_state;
  endtask

  initial begin
    int lat, k0, sent, acc_prev, a0, o0, w;
    int sl [3];
    logic [127:0] res, held;
    logic [127:0] vecs [3];
    logic [7:0] inv, b, s;

    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gf_mul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      s = inv; b = inv;
      for (int r = 0; r < 4; r++) begin b = {b[6:0], b[7]}; s = s ^ b; end
      sbox_tab[v] = s ^ 8'h63;
    end

    // Reset state
    repeat (3) tick();
    check_val("rst_in_ready", 128'(in_ready), 128'd0);
    check_val("rst_out_valid", 128'(out_valid), 128'd0);
    check_val("rst_busy", 128'(busy), 128'd0);
    check_val("rst_out_state", out_state, 128'd0);
    rst = 1'b0;
    tick();
    check_val("post_rst_in_ready", 128'(in_ready), 128'd1);

    // FIPS vector, constants
    send_wait(FIPS_IN, lat, res);
    check_val("fips_latency", 128'(lat), 128'd4);
    check_val("fips_out", res, FIPS_OUT);
    check_val("fips_busy_done", 128'(busy), 128'd1);
    tick();
    check_val("fips_idle_valid", 128'(out_valid), 128'd0);
    check_val("fips_idle_ready", 128'(in_ready), 128'd1);
    check_val("fips_idle_busy", 128'(busy), 128'd0);
    send_wait(128'd0, lat, res);
    check_val("zero_out", res, ALL_63);
    tick();
    send_wait({128{1'b1}}, lat, res);
    check_val("ff_out", res, ALL_16);
    tick();

    // Back-to-back accepts with in_valid held high
    vecs[0] = SEQ_IN; vecs[1] = FIPS_IN; vecs[2] = 128'hDEADBEEF0123456789ABCDEF55AA33CC;
    k0 = acc_cnt;
    in_valid = 1'b1;
    in_state = vecs[0];
    w = 0;
    while (acc_cnt < k0 + 3 && w < 60) begin
      tick(); w++;
      if (acc_cnt - k0 < 3) in_state = vecs[acc_cnt - k0];
    end
    in_valid = 1'b0;
    if (acc_cnt < k0 + 3) check_val("b2b_timeout", 128'd0, 128'd1);
    else begin
      check_val("b2b_gap1", 128'(acc_cyc[k0 + 1] - acc_cyc[k0]), 128'd6);
      check_val("b2b_gap2", 128'(acc_cyc[k0 + 2] - acc_cyc[k0 + 1]), 128'd6);
    end
    repeat (8) tick();

    // Backpressure: out_ready low for 10 cycles, in_valid pressing throughout
    out_ready = 1'b0;
    send_wait(SEQ_IN, lat, res);
    check_val("bp_out", res, SEQ_OUT);
    held = res;
    in_valid = 1'b1;
    in_state = FIPS_IN;
    a0 = acc_cnt;
    o0 = out_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("bp_hold_state", out_state, held);
      check_val("bp_hold_valid", 128'(out_valid), 128'd1);
      check_val("bp_in_ready", 128'(in_ready), 128'd0);
      check_val("bp_busy", 128'(busy), 128'd1);
    end
    out_ready = 1'b1;
    tick();
    check_val("bp_one_handshake", 128'(out_cnt - o0), 128'd1);
    check_val("bp_no_accept_in_done", 128'(acc_cnt - a0), 128'd0);
    check_val("bp_idle_valid", 128'(out_valid), 128'd0);
    check_val("bp_idle_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b0;
    repeat (2) tick();
    check_val("bp_single_output", 128'(out_cnt - o0), 128'd1);

    // Reset in the middle of RUN
    send_wait(FIPS_IN, lat, res);
    tick();
    in_valid = 1'b1;
    in_state = 128'd0;
    tick();
    in_valid = 1'b0;
    o0 = out_cnt;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check_val("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check_val("mid_rst_busy", 128'(busy), 128'd0);
    check_val("mid_rst_out_state", out_state, 128'd0);
    check_val("mid_rst_in_ready", 128'(in_ready), 128'd0);
    tick();
    rst = 1'b0;
    tick();
    check_val("mid_rst_release_ready", 128'(in_ready), 128'd1);
    check_val("mid_rst_no_output", 128'(out_cnt - o0), 128'd0);
    send_wait({128{1'b1}}, lat, res);
    check_val("mid_rst_next_out", res, ALL_16);
    tick();

    // LANES sweep with the FIPS vector
    sl[0] = 0; sl[1] = 0; sl[2] = 0;
    check_val("sweep_ready", 128'(sw_rdy), 128'd7);
    sw_valid = 1'b1;
    sw_state = FIPS_IN;
    tick();
    sw_valid = 1'b0;
    sw_state = 128'd0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        if (sw_ov[d] && sl[d] == 0) begin
          sl[d] = c;
          check_val($sformatf("sweep_out_%0d", d), sw_out[d], FIPS_OUT);
        end
      end
    end
    check_val("sweep_lat_l1", 128'(sl[0]), 128'd16);
    check_val("sweep_lat_l2", 128'(sl[1]), 128'd8);
    check_val("sweep_lat_l16", 128'(sl[2]), 128'd1);

    // Random traffic with gaps and backpressure
    a0 = acc_cnt;
    o0 = out_cnt;
    sent = 0;
    acc_prev = acc_cnt;
    w = 0;
    while (sent < 1000 && w < 40000) begin
      tick(); w++;
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && acc_cnt != acc_prev) begin
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid) begin
        in_state = {$urandom, $urandom, $urandom, $urandom};
        if (sent < 1000 && $urandom_range(0, 2) == 0) begin
          in_valid = 1'b1;
          acc_prev = acc_cnt;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 100) begin tick(); w++; end
    check_val("rnd_sent", 128'(sent), 128'd1000);
    check_val("rnd_accepts", 128'(acc_cnt - a0), 128'd1000);
    check_val("rnd_outputs", 128'(out_cnt - o0), 128'd1000);
    check_val("rnd_drained", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
